// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
// Holds the FSM state type and digit flag encodings.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;

  localparam digit_t DIG_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};
  localparam digit_t DIG_P1   = '{neg: 1'b0, one: 1'b1, two: 1'b0};
  localparam digit_t DIG_P2   = '{neg: 1'b0, one: 1'b0, two: 1'b1};
  localparam digit_t DIG_M1   = '{neg: 1'b1, one: 1'b1, two: 1'b0};
  localparam digit_t DIG_M2   = '{neg: 1'b1, one: 1'b0, two: 1'b1};

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth digit recoder (combinational).
// Ports: bits[2:0] = {y[2i+1], y[2i], y[2i-1]}; neg/one/two digit flags out.
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] bits,
  output logic       neg,
  output logic       one,
  output logic       two
);

  digit_t d;

  always_comb begin
    d = DIG_ZERO;
    unique case (bits)
      3'b000:  d = DIG_ZERO;
      3'b001:  d = DIG_P1;
      3'b010:  d = DIG_P1;
      3'b011:  d = DIG_P2;
      3'b100:  d = DIG_M2;
      3'b101:  d = DIG_M1;
      3'b110:  d = DIG_M1;
      default: d = DIG_ZERO;
    endcase
  end

  assign neg = d.neg;
  assign one = d.one;
  assign two = d.two;

endmodule

// File: rtl/booth_mul_r4.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Ports: clk, rst (async high), start, x, y, tc in; z, valid, busy out.
module booth_mul_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               tc,
  output logic [2*WIDTH-1:0] z,
  output logic               valid,
  output logic               busy
);

  localparam int N    = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mul_r4: WIDTH must be even and >= 4");
  end

  state_t          state;
  logic [EW-1:0]   mcand;
  logic [EW:0]     mplier;
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   cnt;

  logic            neg;
  logic            one;
  logic            two;
  logic [ACCW-1:0] mc_ext;
  logic [ACCW-1:0] mag;
  logic [ACCW-1:0] pp;
  logic [ACCW-1:0] acc_nxt;

  // Low three bits of the shifting multiplier form the current window;
  // bit 0 starts as the implicit zero below the LSB.
  booth_r4_recode u_rec (
    .bits (mplier[2:0]),
    .neg  (neg),
    .one  (one),
    .two  (two)
  );

  always_comb begin
    mc_ext  = {{(ACCW-EW){mcand[EW-1]}}, mcand};
    mag     = '0;
    if (two)
      mag = mc_ext << 1;
    else if (one)
      mag = mc_ext;
    pp      = neg ? (~mag + 1'b1) : mag;
    acc_nxt = acc + (pp << {cnt, 1'b0});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      z      <= '0;
      valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            mcand  <= tc ? {{2{x[WIDTH-1]}}, x}
                         : {2'b00, x};
            mplier <= tc ? {{2{y[WIDTH-1]}}, y, 1'b0}
                         : {2'b00, y, 1'b0};
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 2;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            z     <= acc_nxt[2*WIDTH-1:0];
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_booth_mul_r4.sv
// Self-checking bench for booth_mul_r4 at WIDTH 4, 8 and 16.
// Reference products come from plain integer multiplication.
module tb_booth_mul_r4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  st;
  logic [15:0] xin;
  logic [15:0] yin;
  logic        tcin;
  logic [7:0]  z4;
  logic [15:0] z8;
  logic [31:0] z16;
  logic [2:0]  v;
  logic [2:0]  b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_mul_r4 #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st[0]),
    .x(xin[3:0]), .y(yin[3:0]), .tc(tcin),
    .z(z4), .valid(v[0]), .busy(b[0])
  );

  booth_mul_r4 #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st[1]),
    .x(xin[7:0]), .y(yin[7:0]), .tc(tcin),
    .z(z8), .valid(v[1]), .busy(b[1])
  );

  booth_mul_r4 #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st[2]),
    .x(xin), .y(yin), .tc(tcin),
    .z(z16), .valid(v[2]), .busy(b[2])
  );

  function automatic int wid(input int idx);
    return 4 << idx;
  endfunction

  function automatic logic [31:0] get_z(input int idx);
    case (idx)
      0:       return {24'b0, z4};
      1:       return {16'b0, z8};
      default: return z16;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input int w,
                                          input logic [15:0] a,
                                          input logic [15:0] bb,
                                          input logic t);
    longint m, sa, sb, p;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(bb) & m;
    if (t && sa[w-1]) sa = sa - (longint'(1) << w);
    if (t && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  task automatic run_op(input int idx, input logic [15:0] a,
                        input logic [15:0] bb, input logic t,
                        output logic [31:0] zz, output int lat,
                        output logic bmid, output logic vnext);
    @(negedge clk);
    xin = a; yin = bb; tcin = t; st[idx] = 1'b1;
    @(negedge clk);
    st[idx] = 1'b0;
    bmid = b[idx];
    xin = 16'($urandom); yin = 16'($urandom); tcin = 1'($urandom);
    lat = -1;
    zz = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (v[idx]) begin
        lat = c;
        zz = get_z(idx);
        break;
      end
    end
    @(negedge clk);
    vnext = v[idx];
  endtask

  task automatic test_reset();
    rst = 1'b1; st = '0; xin = '0; yin = '0; tcin = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (get_z(i) !== 32'd0 || v[i] !== 1'b0 || b[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset idx=%0d z=%h valid=%b busy=%b want 0/0/0",
                 i, get_z(i), v[i], b[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] bb;
    logic        t;
    logic [31:0] ez;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[6];
    logic [31:0] zz;
    int lat;
    logic bm, vn;
    tbl[0] = '{0, 16'h3, 16'h6, 1'b1, 32'h12};
    tbl[1] = '{0, 16'h8, 16'h8, 1'b1, 32'h40};
    tbl[2] = '{0, 16'h8, 16'h7, 1'b1, 32'hC8};
    tbl[3] = '{0, 16'hF, 16'hF, 1'b0, 32'hE1};
    tbl[4] = '{0, 16'hF, 16'hF, 1'b1, 32'h01};
    tbl[5] = '{1, 16'h80, 16'h7F, 1'b1, 32'hC080};
    foreach (tbl[i]) begin
      run_op(tbl[i].idx, tbl[i].a, tbl[i].bb, tbl[i].t, zz, lat, bm, vn);
      n_chk++;
      if (zz !== tbl[i].ez) begin
        n_fail++;
        $display("FAIL directed_z[%0d] got=%h want=%h", i, zz, tbl[i].ez);
      end
      n_chk++;
      if (lat !== wid(tbl[i].idx) / 2 + 1) begin
        n_fail++;
        $display("FAIL directed_lat[%0d] got=%0d want=%0d",
                 i, lat, wid(tbl[i].idx) / 2 + 1);
      end
      n_chk++;
      if (vn !== 1'b0 || bm !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_pulse[%0d] vnext=%b busy=%b want 0/1",
                 i, vn, bm);
      end
    end
  endtask

  task automatic test_restart();
    int npulse = 0;
    int first = -1;
    logic [31:0] zz = '0;
    @(negedge clk);
    xin = 16'h80; yin = 16'h7F; tcin = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) begin
        xin = 16'h5; yin = 16'h5; tcin = 1'b0; st[1] = 1'b1;
      end else begin
        st[1] = 1'b0;
      end
      if (v[1]) begin
        npulse++;
        zz = get_z(1);
        if (first < 0) first = c;
      end
    end
    n_chk++;
    if (npulse !== 1 || first !== 5) begin
      n_fail++;
      $display("FAIL restart_pulse got=%0d@%0d want=1@5", npulse, first);
    end
    n_chk++;
    if (zz !== 32'hC080) begin
      n_fail++;
      $display("FAIL restart_z got=%h want=0000c080", zz);
    end
  endtask

  task automatic test_abort();
    int npulse = 0;
    logic [31:0] zz;
    int lat;
    logic bm, vn;
    @(negedge clk);
    xin = 16'd100; yin = 16'd100; tcin = 1'b0; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (z8 !== 16'h0 || b[1] !== 1'b0 || v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state z=%h busy=%b valid=%b want 0/0/0",
               z8, b[1], v[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (v[1]) npulse++;
    end
    n_chk++;
    if (npulse !== 0 || z8 !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_novalid pulses=%0d z=%h want 0/0", npulse, z8);
    end
    run_op(1, 16'd2, 16'd3, 1'b0, zz, lat, bm, vn);
    n_chk++;
    if (zz !== 32'd6 || lat !== 5) begin
      n_fail++;
      $display("FAIL abort_next z=%h lat=%0d want 6/5", zz, lat);
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    int bad = 0;
    @(negedge clk);
    xin = 16'h5; yin = 16'h3; tcin = 1'b0; st[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (v[0]) begin
        hits.push_back(c);
        if (z4 !== 8'd15) bad++;
      end
    end
    st[0] = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++;
    if (hits.size() !== 4 || bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d badz=%0d want 4/0",
               hits.size(), bad);
    end
    for (int i = 1; i < hits.size(); i++) begin
      n_chk++;
      if (hits[i] - hits[i-1] !== 5) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d] got=%0d want 5",
                 i, hits[i] - hits[i-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] zz, ez;
    logic [15:0] a, bb, m;
    logic t, bm, vn;
    int lat, w;
    for (int idx = 0; idx < 3; idx++) begin
      w = wid(idx);
      m = 16'((32'd1 << w) - 1);
      for (int i = 0; i < 30; i++) begin
        a  = 16'($urandom) & m;
        bb = 16'($urandom) & m;
        t  = 1'($urandom);
        if (i < 4) begin
          a  = (i[0]) ? m : (m ^ (m >> 1));
          bb = (i[1]) ? (m >> 1) : (m ^ (m >> 1));
        end
        ez = ref_mul(w, a, bb, t);
        run_op(idx, a, bb, t, zz, lat, bm, vn);
        n_chk++;
        if (zz !== ez) begin
          n_fail++;
          $display("FAIL rand_z w=%0d a=%h b=%h tc=%b got=%h want=%h",
                   w, a, bb, t, zz, ez);
        end
        n_chk++;
        if (lat !== w / 2 + 1) begin
          n_fail++;
          $display("FAIL rand_lat w=%0d got=%0d want=%0d",
                   w, lat, w / 2 + 1);
        end
        n_chk++;
        if (vn !== 1'b0 || bm !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_pulse w=%0d vnext=%b busy=%b want 0/1",
                   w, vn, bm);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_r4.md
BOOTH_MUL_R4 -- requirements
Module: booth_mul_r4

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be even and >= 4 (elaboration error otherwise).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 x  input  WIDTH  multiplicand; captured on accepted start.
REQ-006 y  input  WIDTH  multiplier; captured on accepted start.
REQ-007 tc  input  1  mode: 1 = two's-complement signed, 0 = unsigned; captured on accepted start.
REQ-008 z  output  2*WIDTH  product; registered, holds last result until next completion.
REQ-009 valid  output  1  one-cycle pulse: z carries a new result.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, DONE.
REQ-012 IDLE: start=1 at an edge SHALL capture x, y, tc, clear accumulator and step counter, and go to CALC; start=0 stays in IDLE.
REQ-013 Capture SHALL extend both operands by 2 bits to WIDTH+2 (sign-extend if tc=1, zero-extend if tc=0).
REQ-014 CALC SHALL perform exactly N = WIDTH/2+1 radix-4 Booth steps, one per edge, independent of operand values and mode.
REQ-015 Each step SHALL recode 3 overlapping multiplier bits (initial implicit bit 0) to a digit in {-2,-1,0,+1,+2} and add digit*multiplicand, shifted 2*step, into the accumulator.
REQ-016 The accumulator SHALL be at least 2*WIDTH+4 bits; z SHALL be its low 2*WIDTH bits, exact for all operands in both modes.
REQ-017 On the edge completing step N the FSM SHALL go to DONE and register z; valid SHALL be 1 for the DONE cycle only.
REQ-018 Latency: start sampled at edge k -> valid high in the cycle following edge k+N (WIDTH=8: 5 cycles; WIDTH=4: 3 cycles).
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally; back-to-back throughput is one result per N+2 cycles.
REQ-020 start asserted in CALC or DONE SHALL be ignored (no queueing); x, y, tc changes after capture SHALL not affect the result.
REQ-021 z SHALL change only on the DONE transition or reset.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, z=0, valid=0, busy=0, counter and accumulator 0, regardless of clk.
REQ-023 Reset during CALC or DONE SHALL abort the operation; no valid pulse SHALL follow for it.
REQ-024 The first edge after rst deasserts SHALL accept start normally.

Structure
REQ-025 A shared package booth_pkg SHALL hold the state type (IDLE/CALC/DONE) and the digit encoding constants (neg, one, two flags).
REQ-026 Radix-4 digit recoding SHALL be a combinational sub-module booth_r4_recode (3 bits in; neg, one, two out); the datapath and FSM stay in booth_mul_r4.
REQ-027 Step counter width SHALL be $clog2(N+1).

Verification
REQ-028 WIDTH=4, tc=1, x=3, y=6, start pulse -> valid after 3 cycles, z=18.
REQ-029 WIDTH=4, tc=1, x=-8, y=-8 -> z=64; x=-8, y=7 -> z=-56.
REQ-030 WIDTH=4, tc=0, x=15, y=15 -> z=225; same bits with tc=1 -> z=1.
REQ-031 WIDTH=8, tc=1, x=-128, y=127 -> z=-16256 after 5 cycles; start re-pulsed mid-CALC -> single valid, result unchanged.
REQ-032 WIDTH=8, start x=100, y=100, rst pulsed 2 cycles later -> z=0, busy=0, no valid; next start x=2, y=3 -> z=6.
REQ-033 Random sweep, WIDTH in {4,8,16}, both modes -> every z matches reference product; valid exactly one cycle per accepted start.
